// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment digit scanner.
package seg_pkg;

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } state_t;

    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // Counter width for a count range of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/ack handshake carrying the packed hex word into the scanner.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    load_ack;

    modport master (output load, output data_in, input load_ack);
    modport slave  (input load, input data_in, output load_ack);
endinterface

// File: rtl/seg_prescaler.sv
// Digit on-time prescaler: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed, double-buffered 7-segment digit scanner with inter-digit blanking.
// Optional leading-zero suppression: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        bus,
    output logic [3:0]            digit_nibble,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_start
);

    localparam int IW = cnt_w(NUM_DIGITS);
    localparam int BW = cnt_w(BLANK_CYC);
    localparam int WW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(BLANK_CYC - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    state_t        state;
    logic [IW-1:0] idx;
    logic [BW-1:0] bcnt;
    logic [WW-1:0] shadow;
    logic [WW-1:0] pend_word;
    logic          pend;
    logic          tick;

    logic [IW-1:0] nxt_idx;
    logic          blank_done;
    logic          commit;
    logic          commit_do;
    logic [WW-1:0] commit_word;
    logic [WW-1:0] show_word;
    logic          next_dark;

    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IW-1:0] i, input logic dark);
        logic [NUM_DIGITS-1:0] a;
        a = AN_ALL_OFF;
        if (!dark) a[i] = 1'b0;
        return a;
    endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
    // A digit above 0 goes dark when it and every digit to its left are zero.
    function automatic logic lz_dark(input logic [WW-1:0] w, input logic [IW-1:0] i);
        logic nz;
        nz = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (d >= int'(i) && w[4*d +: 4] != 4'h0) nz = 1'b1;
        end
        return (i != '0) && !nz;
    endfunction
    assign next_dark = lz_dark(show_word, nxt_idx);
`else
    assign next_dark = 1'b0;
`endif

    assign nxt_idx     = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    assign blank_done  = (state == S_BLANK) && (bcnt == B_LAST);
    assign commit      = blank_done && (idx == LAST_IDX);
    assign commit_do   = commit && (bus.load || pend);
    assign commit_word = bus.load ? bus.data_in : pend_word;
    // The word the next lit digit reads from, so a fresh commit shows immediately.
    assign show_word   = commit_do ? commit_word : shadow;

    seg_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != S_SHOW),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BLANK;
            idx          <= LAST_IDX;
            bcnt         <= '0;
            shadow       <= '0;
            pend_word    <= '0;
            pend         <= 1'b0;
            an_n         <= AN_ALL_OFF;
            digit_nibble <= 4'h0;
            bus.load_ack <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            bus.load_ack <= 1'b0;
            frame_start  <= 1'b0;
            if (bus.load && !commit) begin
                pend_word <= bus.data_in;
                pend      <= 1'b1;
            end
            case (state)
                S_SHOW: begin
                    if (tick) begin
                        state <= S_BLANK;
                        an_n  <= AN_ALL_OFF;
                    end
                end
                S_BLANK: begin
                    if (blank_done) begin
                        bcnt         <= '0;
                        state        <= S_SHOW;
                        idx          <= nxt_idx;
                        an_n         <= anode_for(nxt_idx, next_dark);
                        digit_nibble <= show_word[4*nxt_idx +: 4];
                        if (commit) begin
                            frame_start <= 1'b1;
                            if (commit_do) begin
                                shadow       <= commit_word;
                                bus.load_ack <= 1'b1;
                                pend         <= 1'b0;
                            end
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed digit scanner for a multi-digit common-anode 7-segment display. Captures a packed hex word through a load/ack handshake and double-buffers it so that updates take effect only at frame boundaries, with no tearing. Steps through the digits with an inter-digit blanking gap to prevent ghosting. Sits directly upstream of the hex-to-7-segment encoder: its digit_nibble output feeds the encoder's 4-bit input, and an_n drives the board anodes.

Parameters:
NUM_DIGITS, 4, number of display digits (2..8)
CLK_DIV, 50000, clock cycles each digit is lit (>=2)
BLANK_CYC, 8, clock cycles all anodes are off between digits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  single-cycle request to update the display word
data_in  input  4*NUM_DIGITS  packed hex digits; digit 0 = bits [3:0] (rightmost)
load_ack  output  1  one-cycle pulse: the pending word was committed to the display
digit_nibble  output  4  hex value of the currently lit digit, to the 7-seg encoder
an_n  output  NUM_DIGITS  active-low anode enables, at most one bit low
frame_start  output  1  one-cycle pulse when digit 0 becomes lit

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values:
  - an_n = all 1s; digit_nibble = 0; load_ack = 0; frame_start = 0.
  - Shadow word = 0; pending word = 0; pending flag = 0.
  - State = S_BLANK; idx = NUM_DIGITS-1; blank counter = 0; prescaler = 0.
- FSM, two states:
  - S_SHOW: an_n[idx] = 0, all other bits 1; digit_nibble = shadow[4*idx +: 4]. Prescaler counts 0..CLK_DIV-1. At count CLK_DIV-1: go to S_BLANK, prescaler resets to 0. S_SHOW therefore lasts exactly CLK_DIV cycles.
  - S_BLANK: an_n = all 1s; digit_nibble holds its last value. Lasts exactly BLANK_CYC cycles. On exit: idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1, then enter S_SHOW.
- Frame period = NUM_DIGITS*(CLK_DIV+BLANK_CYC) cycles. The first digit-0 lighting occurs BLANK_CYC cycles after reset release.
- Commit (wrap): on the S_BLANK->S_SHOW edge where idx wraps to 0:
  - frame_start = 1 for one cycle (the first cycle of S_SHOW for digit 0).
  - If the pending flag is set, or load is high in that same cycle: shadow <= word, load_ack = 1 for one cycle, pending flag cleared.
  - Word selection: if load is high in the commit cycle, data_in is committed directly; otherwise the pending word is committed.
  - digit_nibble in that first S_SHOW cycle already reflects the new shadow.
- Load handling outside the commit cycle: load=1 copies data_in to the pending word and sets the pending flag. A second load before commit overwrites the pending word (latest wins); only one load_ack is produced.
- load_ack is never asserted without a preceding or coincident load.
- Reset mid-frame: anodes turn off immediately (asynchronous). Any pending word is discarded.
- Invariant: an_n never has more than one bit low in any cycle.

Optional Feature:
Macro: SEG_SCAN_LZ_BLANK_EN
- Defined: leading-zero suppression. Digit idx > 0 is blanked (an_n stays all 1s during its S_SHOW slot) when shadow digits idx..NUM_DIGITS-1 are all 0. Digit 0 is always lit. Slot timing is unchanged.
- Undefined: every digit is lit in its slot.

Decomposition:
- Shared package seg_pkg holds:
  - state encoding: S_SHOW, S_BLANK
  - constant AN_OFF (all 1s)
  - localparam helper for the prescaler width: $clog2(CLK_DIV)
- One natural sub-module: seg_prescaler. Parameterised by CLK_DIV; inputs clk, rst_n, clear; output tick at count CLK_DIV-1.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=4, BLANK_CYC=1.
- Reset release, no load -> an_n sequence 1111(1 cycle), 1110(4), 1111(1), 1101(4), 1111(1), 1011(4), ...; digit_nibble=0; frame_start pulses every 20 cycles.
- Load 16'h12AF mid-frame -> no display change until wrap; at the next frame_start, load_ack=1 and the digits show F, A, 2, 1 for idx 0..3.
- Two loads (16'h1111, then 16'h2222) within one frame -> single load_ack; display 2222.
- load with 16'h00C3 asserted exactly in the commit cycle -> load_ack in the same cycle; digit 0 shows 3 immediately.
- Assert rst_n=0 while digit 2 is lit -> an_n=1111 asynchronously; after release the sequence restarts as in scenario 1 and the pending word is lost.
- With SEG_SCAN_LZ_BLANK_EN and word 16'h0050 -> digits 2 and 3 stay dark; digits 0 and 1 are lit (values 0 and 5).
